// File: rtl/sega_pad_pkg.sv
// Shared constants, types and page selection for the Sega Mega Drive pad emulator.
package sega_pad_pkg;

  localparam int BTN_UP    = 0;
  localparam int BTN_DN    = 1;
  localparam int BTN_LT    = 2;
  localparam int BTN_RT    = 3;
  localparam int BTN_B     = 4;
  localparam int BTN_C     = 5;
  localparam int BTN_A     = 6;
  localparam int BTN_START = 7;
  localparam int BTN_Z     = 8;
  localparam int BTN_Y     = 9;
  localparam int BTN_X     = 10;
  localparam int BTN_MODE  = 11;

  localparam int PIN_UP = 0;
  localparam int PIN_DN = 1;
  localparam int PIN_LT = 2;
  localparam int PIN_RT = 3;
  localparam int PIN_BA = 4;
  localparam int PIN_CS = 5;

  localparam int TIMEOUT_CYC_DEF = 21000;

  typedef logic [2:0] phase_t;

  typedef enum logic [2:0] {PG_STD, PG_LOW, PG_ID, PG_EXT, PG_LOW4} page_e;

  // A low SEL with count 0 (e.g. after a timeout with SEL held low) reads as the first low page.
  function automatic page_e page_for(input logic sel_hi, input phase_t cnt);
    page_e pg;
    if (sel_hi) begin
      pg = (cnt == 3'd3) ? PG_EXT : PG_STD;
    end else begin
      case (cnt)
        3'd3:    pg = PG_ID;
        3'd4:    pg = PG_LOW4;
        default: pg = PG_LOW;
      endcase
    end
    return pg;
  endfunction

endpackage

// File: rtl/sega_pad_emu_sel_sync_edge.sv
// Two-flop synchroniser for the asynchronous SEL line plus single-cycle rise/fall pulses.
module sel_sync_edge (
  input  logic clk14,
  input  logic reset,
  input  logic sel_in,
  output logic sel_s,
  output logic sel_rise,
  output logic sel_fall
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d = sel_in;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  // NOTE: non-blocking assignments make every flop sample its pre-edge input, so the chain shifts by one stage per clock.
  always_ff @(posedge clk14 or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign sel_s    = sync_q;
  assign sel_rise = sync_q & ~prev_q;
  assign sel_fall = ~sync_q & prev_q;

endmodule

// File: rtl/sega_pad_emu.sv
// Sega Mega Drive 3/6-button pad emulator answering host SEL phases on active-low pins.
// Optional autofire on TURBO_MASK buttons when SEGA_PAD_TURBO_EN is defined.
module sega_pad_emu
  import sega_pad_pkg::*;
#(
  parameter int          TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter bit          SIX_BTN     = 1'b1,
  parameter logic [11:0] TURBO_MASK  = 12'h000,
  parameter int          TURBO_HALF  = 143180
) (
  input  logic        clk14,
  input  logic        reset,
  input  logic        sel,
  input  logic [11:0] buttons,
  output logic [5:0]  pad,
  output logic [2:0]  phase
);

  localparam phase_t          CNT_MAX = SIX_BTN ? 3'd4 : 3'd2;
  localparam int              TO_W    = $clog2(TIMEOUT_CYC);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  logic sel_s, sel_rise, sel_fall, sel_edge;

  sel_sync_edge u_sel_sync (
    .clk14    (clk14),
    .reset    (reset),
    .sel_in   (sel),
    .sel_s    (sel_s),
    .sel_rise (sel_rise),
    .sel_fall (sel_fall)
  );

  assign sel_edge = sel_rise | sel_fall;

  logic [11:0] btn;

`ifdef SEGA_PAD_TURBO_EN
  localparam int               DIV_W    = $clog2(TURBO_HALF);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TURBO_HALF - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             turbo_q, turbo_d;

  always_comb begin
    div_d   = div_q + DIV_W'(1);
    turbo_d = turbo_q;
    if (div_q == DIV_LAST) begin
      div_d   = '0;
      turbo_d = ~turbo_q;
    end
  end

  always_ff @(posedge clk14 or posedge reset) begin
    if (reset) begin
      div_q   <= '0;
      turbo_q <= 1'b0;
    end else begin
      div_q   <= div_d;
      turbo_q <= turbo_d;
    end
  end

  assign btn = buttons & ~(TURBO_MASK & {12{~turbo_q}});
`else
  logic unused_turbo;
  assign unused_turbo = ^{TURBO_MASK, 32'(TURBO_HALF)};
  assign btn = buttons;
`endif

  logic [TO_W-1:0] to_q, to_d;
  phase_t          cnt_q, cnt_d;
  logic [5:0]      pad_q, pad_d;
  page_e           page;

  // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
  always_comb begin
    to_d  = to_q;
    cnt_d = cnt_q;
    if (sel_edge) begin
      to_d = '0;
      if (sel_fall && cnt_q != CNT_MAX) cnt_d = cnt_q + 3'd1;
    end else if (to_q == TO_LAST) begin
      cnt_d = '0;
    end else begin
      to_d = to_q + TO_W'(1);
    end

    // The page follows the updated count so a new phase shows up one register after the synchroniser.
    page  = page_for(sel_s, cnt_d);
    pad_d = '1;
    case (page)
      PG_STD: begin
        pad_d[PIN_UP] = ~btn[BTN_UP];
        pad_d[PIN_DN] = ~btn[BTN_DN];
        pad_d[PIN_LT] = ~btn[BTN_LT];
        pad_d[PIN_RT] = ~btn[BTN_RT];
        pad_d[PIN_BA] = ~btn[BTN_B];
        pad_d[PIN_CS] = ~btn[BTN_C];
      end
      PG_LOW: begin
        pad_d[PIN_UP] = ~btn[BTN_UP];
        pad_d[PIN_DN] = ~btn[BTN_DN];
        pad_d[PIN_LT] = 1'b0;
        pad_d[PIN_RT] = 1'b0;
        pad_d[PIN_BA] = ~btn[BTN_A];
        pad_d[PIN_CS] = ~btn[BTN_START];
      end
      PG_ID: begin
        pad_d[PIN_RT:PIN_UP] = 4'b0000;
        pad_d[PIN_BA]        = ~btn[BTN_A];
        pad_d[PIN_CS]        = ~btn[BTN_START];
      end
      PG_EXT: begin
        pad_d[PIN_UP] = ~btn[BTN_Z];
        pad_d[PIN_DN] = ~btn[BTN_Y];
        pad_d[PIN_LT] = ~btn[BTN_X];
        pad_d[PIN_RT] = ~btn[BTN_MODE];
        pad_d[PIN_BA] = ~btn[BTN_B];
        pad_d[PIN_CS] = ~btn[BTN_C];
      end
      PG_LOW4: begin
        pad_d[PIN_BA] = ~btn[BTN_A];
        pad_d[PIN_CS] = ~btn[BTN_START];
      end
      default: pad_d = '1;
    endcase
  end

  always_ff @(posedge clk14 or posedge reset) begin
    if (reset) begin
      to_q  <= '0;
      cnt_q <= '0;
      pad_q <= 6'h3F;
    end else begin
      to_q  <= to_d;
      cnt_q <= cnt_d;
      pad_q <= pad_d;
    end
  end

  assign pad   = pad_q;
  assign phase = cnt_q;

endmodule
